// File: rtl/risc_pkg.sv
// Shared types and instruction-field positions for the parametrised multicycle RISC core.
package risc_pkg;

  localparam int INSTR_W = 16;
  localparam int OP_HI   = 15;
  localparam int OP_LO   = 12;
  localparam int RD_HI   = 11;
  localparam int RD_LO   = 8;
  localparam int IMM_HI  = 7;
  localparam int IMM_LO  = 0;
  localparam int RS_HI   = 3;
  localparam int RS_LO   = 0;

  typedef enum logic [3:0] {
    OP_HALT = 4'h0,
    OP_LDI  = 4'h1,
    OP_MOV  = 4'h2,
    OP_ADD  = 4'h3,
    OP_SUB  = 4'h4,
    OP_AND  = 4'h5,
    OP_OR   = 4'h6,
    OP_XOR  = 4'h7,
    OP_SHL  = 4'h8,
    OP_SHR  = 4'h9,
    OP_LD   = 4'hA,
    OP_ST   = 4'hB,
    OP_BZ   = 4'hC,
    OP_BNZ  = 4'hD,
    OP_JMP  = 4'hE,
    OP_DEC  = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_DONE
  } state_e;

endpackage

// File: rtl/risc_alu_p.sv
// Combinational ALU: result plus zero and carry/borrow flags for the arithmetic, logic and shift ops.
module risc_alu_p
  import risc_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  opcode_e           op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] y_o,
  output logic              z_o,
  output logic              c_o
);

  always_comb begin
    // NOTE: every output is given a default first so no path through the case infers a latch.
    y_o = a_i;
    c_o = 1'b0;
    case (op_i)
      OP_ADD:  {c_o, y_o} = {1'b0, a_i} + {1'b0, b_i};
      OP_SUB:  {c_o, y_o} = {1'b0, a_i} - {1'b0, b_i};
      OP_DEC:  {c_o, y_o} = {1'b0, a_i} - (DATA_W + 1)'(1);
      OP_AND:  y_o = a_i & b_i;
      OP_OR:   y_o = a_i | b_i;
      OP_XOR:  y_o = a_i ^ b_i;
      OP_MOV:  y_o = b_i;
      OP_SHL: begin
        y_o = {a_i[DATA_W-2:0], 1'b0};
        c_o = a_i[DATA_W-1];
      end
      OP_SHR: begin
        y_o = {1'b0, a_i[DATA_W-1:1]};
        c_o = a_i[0];
      end
      default: y_o = a_i;
    endcase
  end

  assign z_o = (y_o == '0);

endmodule

// File: rtl/risc_core_p.sv
// Parametrised multicycle RISC core: one program per req/ack handshake, slot-selected start
// address, external synchronous IMEM/DMEM, and a busy-cycle watchdog that forces a fault stop.
module risc_core_p
  import risc_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int NREGS    = 16,
  parameter int IMEM_AW  = 8,
  parameter int DMEM_AW  = 8,
  parameter int NPROG    = 4,
  parameter int WDOG_MAX = 1024,
  localparam int PS_W    = (NPROG > 1) ? $clog2(NPROG) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req,
  input  logic [PS_W-1:0]    prog_sel,
  output logic               ack,
  output logic               busy,
  output logic               fault,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic               dmem_we,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic [DATA_W-1:0]  dmem_rdata
);

  localparam int RIDX_W  = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam int WDOG_W  = $clog2(WDOG_MAX + 1);
  localparam int SLOT_SH = IMEM_AW - PS_W;

  state_e             state_q, state_d;
  logic [IMEM_AW-1:0] pc_q, pc_d;
  logic [WDOG_W-1:0]  wdog_q, wdog_d;
  logic               fault_q, fault_d;
  logic               z_q, z_d, c_q, c_d;
  logic [RIDX_W-1:0]  ld_rd_q, ld_rd_d;
  logic [DATA_W-1:0]  regs_q [NREGS];

  opcode_e            op;
  logic [3:0]         rd_f, rs_f;
  logic [7:0]         imm8;
  logic [RIDX_W-1:0]  rd_idx, rs_idx;
  logic [DATA_W-1:0]  rd_val, rs_val;
  logic               uses_rd, uses_rs, bad_idx;
  logic               is_exec, wdog_abort, mem_op;
  logic [IMEM_AW-1:0] slot_base, branch_tgt;

  logic               rf_we;
  logic [RIDX_W-1:0]  rf_waddr;
  logic [DATA_W-1:0]  rf_wdata;

  logic [DATA_W-1:0]  alu_y;
  logic               alu_z, alu_c;

  assign op         = opcode_e'(imem_data[OP_HI:OP_LO]);
  assign rd_f       = imem_data[RD_HI:RD_LO];
  assign rs_f       = imem_data[RS_HI:RS_LO];
  assign imm8       = imem_data[IMM_HI:IMM_LO];
  assign rd_idx     = rd_f[RIDX_W-1:0];
  assign rs_idx     = rs_f[RIDX_W-1:0];
  assign rd_val     = regs_q[rd_idx];
  assign rs_val     = regs_q[rs_idx];
  assign slot_base  = IMEM_AW'(prog_sel) << SLOT_SH;
  assign branch_tgt = IMEM_AW'(imm8);

  always_comb begin
    uses_rd = 1'b1;
    uses_rs = 1'b0;
    case (op)
      OP_HALT, OP_BZ, OP_BNZ, OP_JMP: uses_rd = 1'b0;
      OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LD, OP_ST: uses_rs = 1'b1;
      default: ;
    endcase
  end

  assign bad_idx    = (uses_rd && (int'(rd_f) >= NREGS)) || (uses_rs && (int'(rs_f) >= NREGS));
  assign is_exec    = (state_q == S_EXEC);
  assign busy       = (state_q == S_FETCH) || is_exec || (state_q == S_MEM);
  assign ack        = (state_q == S_DONE);
  assign fault      = fault_q;
  assign wdog_abort = busy && (wdog_q == WDOG_W'(WDOG_MAX - 1));

  // Outputs decode straight from state so an async reset clears them in the same cycle.
  assign imem_addr  = pc_q;
  assign mem_op     = is_exec && !bad_idx && ((op == OP_LD) || (op == OP_ST));
  assign dmem_addr  = mem_op ? rs_val[DMEM_AW-1:0] : '0;
  assign dmem_we    = is_exec && !bad_idx && (op == OP_ST) && !wdog_abort;
  assign dmem_wdata = dmem_we ? rd_val : '0;

  risc_alu_p #(.DATA_W(DATA_W)) u_alu (
    .op_i (op),
    .a_i  (rd_val),
    .b_i  (rs_val),
    .y_o  (alu_y),
    .z_o  (alu_z),
    .c_o  (alu_c)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    wdog_d   = busy ? wdog_q + 1'b1 : wdog_q;
    fault_d  = fault_q;
    z_d      = z_q;
    c_d      = c_q;
    ld_rd_d  = ld_rd_q;
    rf_we    = 1'b0;
    rf_waddr = rd_idx;
    rf_wdata = alu_y;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          pc_d    = slot_base;
          wdog_d  = '0;
          fault_d = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_EXEC;
      S_EXEC: begin
        pc_d    = pc_q + 1'b1;
        state_d = S_FETCH;
        if (bad_idx) begin
          fault_d = 1'b1;
          state_d = S_DONE;
        end else begin
          case (op)
            OP_HALT: state_d = S_DONE;
            OP_LDI: begin
              rf_we    = 1'b1;
              rf_wdata = DATA_W'(imm8);
            end
            OP_MOV: rf_we = 1'b1;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_DEC: begin
              rf_we = 1'b1;
              z_d   = alu_z;
              c_d   = alu_c;
            end
            OP_LD: begin
              ld_rd_d = rd_idx;
              state_d = S_MEM;
            end
            OP_BZ:   if (z_q)  pc_d = branch_tgt;
            OP_BNZ:  if (!z_q) pc_d = branch_tgt;
            OP_JMP:  pc_d = branch_tgt;
            default: ;
          endcase
        end
      end
      S_MEM: begin
        rf_we    = 1'b1;
        rf_waddr = ld_rd_q;
        rf_wdata = dmem_rdata;
        state_d  = S_FETCH;
      end
      S_DONE:  if (!req) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // The watchdog wins over whatever the current instruction wanted to commit.
    if (wdog_abort) begin
      rf_we   = 1'b0;
      z_d     = z_q;
      c_d     = c_q;
      pc_d    = pc_q;
      fault_d = 1'b1;
      state_d = S_DONE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      wdog_q  <= '0;
      fault_q <= 1'b0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      ld_rd_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      wdog_q  <= wdog_d;
      fault_q <= fault_d;
      z_q     <= z_d;
      c_q     <= c_d;
      ld_rd_q <= ld_rd_d;
    end
  end

  // NOTE: the register file must read zero after reset, so it is built from resettable flops
  // rather than a RAM macro; only the architectural state justifies resetting a memory.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (rf_we) begin
      regs_q[rf_waddr] <= rf_wdata;
    end
  end

endmodule

// File: tb/tb_risc_core_p.sv
// Directed bench for risc_core_p: small programs in a modelled IMEM, results read back from DMEM.
module tb_risc_core_p;

  localparam int WDOG = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic [1:0]  prog_sel;
  logic        ack, busy, fault;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic [7:0]  dmem_addr;
  logic        dmem_we;
  logic [7:0]  dmem_wdata;
  logic [7:0]  dmem_rdata;

  logic [15:0] imem [256];
  logic [7:0]  dmem [256];
  logic [15:0] prog [8];

  int n_vec = 0;
  int n_err = 0;

  risc_core_p #(
    .DATA_W(8), .NREGS(16), .IMEM_AW(8), .DMEM_AW(8), .NPROG(4), .WDOG_MAX(WDOG)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .prog_sel   (prog_sel),
    .ack        (ack),
    .busy       (busy),
    .fault      (fault),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .dmem_addr  (dmem_addr),
    .dmem_we    (dmem_we),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous-read memories: data appears the cycle after the address.
  always @(posedge clk) begin
    imem_data  <= imem[imem_addr];
    dmem_rdata <= dmem[dmem_addr];
    if (dmem_we) dmem[dmem_addr] = dmem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic load(input int base);
    for (int i = 0; i < 8; i++) imem[base + i] = prog[i];
  endtask

  // Start a run on the given slot and sample each cycle at the falling edge until ack.
  task automatic run(input logic [1:0] sel, output int cyc, output bit we_seen,
                     output logic [7:0] first_pc);
    bit done;
    done     = 1'b0;
    cyc      = 0;
    we_seen  = 1'b0;
    first_pc = 8'hFF;
    @(negedge clk);
    prog_sel = sel;
    req      = 1'b1;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (busy) begin
        if (cyc == 0) first_pc = imem_addr;
        cyc++;
      end
      if (dmem_we) we_seen = 1'b1;
      if (ack) done = 1'b1;
    end
    check("run_ack", done, 1);
  endtask

  task automatic end_run();
    repeat (2) begin
      @(negedge clk);
      check("ack_hold", ack, 1);
    end
    req = 1'b0;
    @(negedge clk);
    check("ack_drop", ack, 0);
  endtask

  int         cyc;
  bit         we;
  logic [7:0] fpc;
  bit         got_ack;

  initial begin
    reset    = 1'b0;
    req      = 1'b0;
    prog_sel = 2'd0;
    for (int i = 0; i < 256; i++) begin
      imem[i] = 16'h0000;
      dmem[i] = 8'hEE;
    end
    dmem[8'h30] = 8'h5A;

    repeat (3) @(negedge clk);
    check("rst_ack", ack, 0);
    check("rst_busy", busy, 0);
    check("rst_fault", fault, 0);
    check("rst_imem_addr", imem_addr, 0);
    check("rst_dmem_we", dmem_we, 0);
    check("rst_dmem_addr", dmem_addr, 0);
    check("rst_dmem_wdata", dmem_wdata, 0);
    reset = 1'b1;

    // Slot 0: LDI r1,5; LDI r2,3; ADD r1,r2; ST r1,[r2]; HALT
    prog = '{16'h1105, 16'h1203, 16'h3102, 16'hB102, 16'h0000, 16'h0, 16'h0, 16'h0};
    load(8'h00);
    run(2'd0, cyc, we, fpc);
    check("t1_first_pc", fpc, 8'h00);
    check("t1_cycles", cyc, 10);
    check("t1_st_seen", we, 1);
    check("t1_fault", fault, 0);
    check("t1_dmem3", dmem[3], 8'h08);
    end_run();

    // Slot 1: LDI r0,4; DEC r0; BNZ 0x41; HALT
    prog = '{16'h1004, 16'hF000, 16'hD041, 16'h0000, 16'h0, 16'h0, 16'h0, 16'h0};
    load(8'h40);
    run(2'd1, cyc, we, fpc);
    check("t2_first_pc", fpc, 8'h40);
    check("t2_cycles", cyc, 20);
    check("t2_r0", dut.regs_q[0], 8'h00);
    check("t2_z", dut.z_q, 1);
    check("t2_c", dut.c_q, 0);
    check("t2_fault", fault, 0);
    end_run();

    // Slot 2, 0xFF + 0x01
    prog = '{16'h1320, 16'h11FF, 16'h1201, 16'h3102, 16'hB103, 16'h0000, 16'h0, 16'h0};
    load(8'h80);
    run(2'd2, cyc, we, fpc);
    check("t3_first_pc", fpc, 8'h80);
    check("add_y", dmem[8'h20], 8'h00);
    check("add_z", dut.z_q, 1);
    check("add_c", dut.c_q, 1);
    end_run();

    // 0x00 - 0x01
    prog = '{16'h1321, 16'h1100, 16'h1201, 16'h4102, 16'hB103, 16'h0000, 16'h0, 16'h0};
    load(8'h80);
    run(2'd2, cyc, we, fpc);
    check("sub_y", dmem[8'h21], 8'hFF);
    check("sub_z", dut.z_q, 0);
    check("sub_c", dut.c_q, 1);
    end_run();

    // SHL 0x80
    prog = '{16'h1322, 16'h1180, 16'h8100, 16'hB103, 16'h0000, 16'h0, 16'h0, 16'h0};
    load(8'h80);
    run(2'd2, cyc, we, fpc);
    check("shl_y", dmem[8'h22], 8'h00);
    check("shl_z", dut.z_q, 1);
    check("shl_c", dut.c_q, 1);
    end_run();

    // LD 0x5A from [0x30], XOR 0x0F, store to [0x31]
    prog = '{16'h1330, 16'hA403, 16'h150F, 16'h7405, 16'h1631, 16'hB406, 16'h0000, 16'h0};
    load(8'h80);
    run(2'd2, cyc, we, fpc);
    check("ld_cycles", cyc, 15);
    check("xor_y", dmem[8'h31], 8'h55);
    check("xor_z", dut.z_q, 0);
    check("xor_c", dut.c_q, 0);
    end_run();

    // Slot 3: the watchdog expires exactly on the EXEC of the ST
    prog = '{16'h100F, 16'hF000, 16'hD0C1, 16'hB102, 16'h0000, 16'h0, 16'h0, 16'h0};
    load(8'hC0);
    run(2'd3, cyc, we, fpc);
    check("wd_st_cycles", cyc, WDOG);
    check("wd_st_no_we", we, 0);
    check("wd_st_fault", fault, 1);
    end_run();
    check("wd_fault_held_idle", fault, 1);

    // Slot 3: JMP to its own slot base forever
    prog = '{16'hE0C0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    load(8'hC0);
    run(2'd3, cyc, we, fpc);
    check("wd_jmp_first_pc", fpc, 8'hC0);
    check("wd_jmp_cycles", cyc, WDOG);
    check("wd_jmp_no_we", we, 0);
    check("wd_jmp_fault", fault, 1);
    end_run();

    // A clean run after a fault must clear the fault flag.
    run(2'd0, cyc, we, fpc);
    check("refault_clear", fault, 0);
    end_run();

    // Drop req mid-run: the run completes and ack lasts one cycle.
    @(negedge clk);
    prog_sel = 2'd0;
    req      = 1'b1;
    repeat (3) @(negedge clk);
    req     = 1'b0;
    got_ack = 1'b0;
    for (int i = 0; i < 40 && !got_ack; i++) begin
      @(negedge clk);
      if (ack) got_ack = 1'b1;
    end
    check("drop_ack", got_ack, 1);
    @(negedge clk);
    check("drop_ack_1cyc", ack, 0);

    // Async reset in the middle of a looping run.
    @(negedge clk);
    prog_sel = 2'd3;
    req      = 1'b1;
    repeat (5) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ack", ack, 0);
    check("mid_rst_fault", fault, 0);
    check("mid_rst_imem_addr", imem_addr, 0);
    check("mid_rst_dmem_we", dmem_we, 0);
    check("mid_rst_regs", dut.regs_q[4], 8'h00);
    req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
